// File: rtl/bsg_gray_ptr_pkg.sv
// Shared helpers for the gray-pointer FIFO controllers.
package bsg_gray_ptr_pkg;

    // Pointers carry one extra wrap bit beyond the address width.
    function automatic int ptr_width(int lg_size);
        return lg_size + 1;
    endfunction

    // Callers zero-extend the pointer into 32 bits and truncate the result.
    // The low bits of the gray code do not depend on the zero upper bits.
    function automatic logic [31:0] binary_to_gray(logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/bsg_gray_to_binary.sv
// Gray-to-binary conversion: each binary bit is the XOR of all gray bits at or above it.
module bsg_gray_to_binary #(
    parameter int width_p = 4
) (
    input  logic [width_p-1:0] gray_i,
    output logic [width_p-1:0] binary_o
);

    for (genvar i = 0; i < width_p; i++) begin : g_bit
        assign binary_o[i] = ^gray_i[width_p-1:i];
    end

endmodule

// File: rtl/bsg_gray_ptr_wr_ctrl.sv
// Write-side pointer controller for a gray-pointer FIFO: binary write pointer,
// registered gray export, full/occupancy from the synchronized read pointer, sticky error.
module bsg_gray_ptr_wr_ctrl
    import bsg_gray_ptr_pkg::*;
#(
    parameter int lg_size_p = 3
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic                 v_i,
    output logic                 ready_o,
    output logic [lg_size_p-1:0] w_addr_o,
    output logic [lg_size_p:0]   w_ptr_gray_o,
    input  logic [lg_size_p:0]   r_ptr_gray_i,
    output logic                 full_o,
    output logic [lg_size_p:0]   count_o,
    output logic                 error_o
);

    localparam int ptr_w_lp = ptr_width(lg_size_p);
    localparam int depth_lp = 1 << lg_size_p;
    localparam logic [ptr_w_lp-1:0] depth_ptr_lp = ptr_w_lp'(depth_lp);

    logic [ptr_w_lp-1:0] w_bin_q, w_bin_d;
    logic [ptr_w_lp-1:0] w_gray_q, w_gray_d;
    logic [ptr_w_lp-1:0] r_bin_q, r_bin;
    logic [ptr_w_lp-1:0] r_gray_q;
    logic                error_q, error_d;
    logic [ptr_w_lp-1:0] count;
    logic [ptr_w_lp-1:0] r_gray_diff;
    logic                gray_skip, overrun, accept;

    bsg_gray_to_binary #(.width_p(ptr_w_lp)) r_g2b (
        .gray_i   (r_ptr_gray_i),
        .binary_o (r_bin)
    );

    // Occupancy uses only registered pointers, so full can lag release by a cycle but never lead it.
    assign count  = w_bin_q - r_bin_q;
    assign full_o = (count == depth_ptr_lp);
    assign accept = v_i & ~full_o;

    assign w_bin_d  = accept ? w_bin_q + ptr_w_lp'(1) : w_bin_q;
    assign w_gray_d = ptr_w_lp'(binary_to_gray(32'(w_bin_d)));

    // More than one bit set in the delta means the incoming gray code skipped a step.
    assign r_gray_diff = r_ptr_gray_i ^ r_gray_q;
    assign gray_skip   = (r_gray_diff & (r_gray_diff - ptr_w_lp'(1))) != '0;
    assign overrun     = count > depth_ptr_lp;
    assign error_d     = error_q | gray_skip | overrun;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            w_bin_q  <= '0;
            w_gray_q <= '0;
            r_bin_q  <= '0;
            r_gray_q <= '0;
            error_q  <= 1'b0;
        end else begin
            w_bin_q  <= w_bin_d;
            w_gray_q <= w_gray_d;
            r_bin_q  <= r_bin;
            r_gray_q <= r_ptr_gray_i;
            error_q  <= error_d;
        end
    end

    assign ready_o      = ~full_o;
    assign w_addr_o     = w_bin_q[lg_size_p-1:0];
    assign w_ptr_gray_o = w_gray_q;
    assign count_o      = count;
    assign error_o      = error_q;

endmodule

// File: tb/tb_bsg_gray_ptr_wr_ctrl.sv
// Directed bench for bsg_gray_ptr_wr_ctrl at lg_size_p=3 (depth 8).
module tb_bsg_gray_ptr_wr_ctrl;

    logic       clk_i = 1'b0;
    logic       reset_n_i;
    logic       v_i;
    logic       ready_o;
    logic [2:0] w_addr_o;
    logic [3:0] w_ptr_gray_o;
    logic [3:0] r_ptr_gray_i;
    logic       full_o;
    logic [3:0] count_o;
    logic       error_o;

    int tests  = 0;
    int failed = 0;

    // 4-bit gray code of 0..15, written out by hand
    logic [3:0] gtab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                              4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

    bsg_gray_ptr_wr_ctrl #(.lg_size_p(3)) dut (
        .clk_i        (clk_i),
        .reset_n_i    (reset_n_i),
        .v_i          (v_i),
        .ready_o      (ready_o),
        .w_addr_o     (w_addr_o),
        .w_ptr_gray_o (w_ptr_gray_o),
        .r_ptr_gray_i (r_ptr_gray_i),
        .full_o       (full_o),
        .count_o      (count_o),
        .error_o      (error_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " gray"},  32'(w_ptr_gray_o), 0);
        chk({tag, " addr"},  32'(w_addr_o), 0);
        chk({tag, " count"}, 32'(count_o), 0);
        chk({tag, " ready"}, 32'(ready_o), 1);
        chk({tag, " full"},  32'(full_o), 0);
        chk({tag, " error"}, 32'(error_o), 0);
    endtask

    initial begin
        reset_n_i    = 1'b0;
        v_i          = 1'b0;
        r_ptr_gray_i = 4'h0;
        #3;
        chk_idle("reset_initial");
        tick();
        reset_n_i = 1'b1;

        // fill to full with back-to-back enqueues
        for (int i = 0; i < 8; i++) begin
            v_i = 1'b1;
            #1;
            chk($sformatf("fill addr %0d", i), 32'(w_addr_o), 32'(i));
            chk($sformatf("fill ready %0d", i), 32'(ready_o), 1);
            tick();
            chk($sformatf("fill gray %0d", i), 32'(w_ptr_gray_o), 32'(gtab[i+1]));
        end
        chk("full flag", 32'(full_o), 1);
        chk("full ready", 32'(ready_o), 0);
        chk("full count", 32'(count_o), 8);
        tick();
        chk("ninth gray", 32'(w_ptr_gray_o), 32'h0C);
        chk("ninth count", 32'(count_o), 8);
        chk("ninth error", 32'(error_o), 0);
        v_i = 1'b0;

        // one read released: full persists until the read pointer is registered
        r_ptr_gray_i = 4'h1;
        #1;
        chk("release full lag", 32'(full_o), 1);
        tick();
        chk("release full", 32'(full_o), 0);
        chk("release count", 32'(count_o), 7);
        chk("release error", 32'(error_o), 0);

        // asynchronous reset between edges
        #2;
        reset_n_i = 1'b0;
        #1;
        chk_idle("reset_mid");
        r_ptr_gray_i = 4'h0;
        tick();
        reset_n_i = 1'b1;

        // 16 accepts, reader two steps behind, pointer wraps
        for (int i = 0; i < 16; i++) begin
            r_ptr_gray_i = (i >= 2) ? gtab[i-2] : 4'h0;
            v_i = 1'b1;
            #1;
            chk($sformatf("wrap addr %0d", i), 32'(w_addr_o), 32'(i % 8));
            chk($sformatf("wrap ready %0d", i), 32'(ready_o), 1);
            tick();
            chk($sformatf("wrap gray %0d", i), 32'(w_ptr_gray_o), 32'(gtab[(i+1)%16]));
            chk($sformatf("wrap error %0d", i), 32'(error_o), 0);
        end
        v_i = 1'b0;
        chk("wrap count", 32'(count_o), 3);

        // two-bit jump on the read pointer
        reset_n_i = 1'b0;
        r_ptr_gray_i = 4'h0;
        tick();
        reset_n_i = 1'b1;
        tick();
        r_ptr_gray_i = 4'h3;
        tick();
        chk("skip error set", 32'(error_o), 1);
        tick();
        tick();
        tick();
        chk("skip error sticky", 32'(error_o), 1);
        reset_n_i = 1'b0;
        #1;
        chk("skip error cleared", 32'(error_o), 0);
        r_ptr_gray_i = 4'h0;
        tick();
        reset_n_i = 1'b1;

        // read pointer overtakes the write pointer
        r_ptr_gray_i = 4'h1;
        tick();
        chk("overrun count", 32'(count_o), 32'h0F);
        chk("overrun no early error", 32'(error_o), 0);
        tick();
        chk("overrun error", 32'(error_o), 1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: observed no finish expected finish by 20000");
        $fatal(1, "timeout");
    end

endmodule
